// File: rtl/piso_pkg.sv
// piso_pkg: definitions shared by both ends of the 4-bit right-shift serial link.
//   - state_t   : transmitter FSM encoding (IDLE / SHIFT / PARITY)
//   - PISO_WIDTH: default frame width. The right-shift receiver uses the same
//                 value, so both ends agree on the frame size.
package piso_pkg;

    localparam int PISO_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in, serial-out transmitter, LSB first.
// A word is accepted on load_valid && load_ready while the FSM is in IDLE.
// The word is then sent one bit per clock. done pulses for one cycle in the
// first IDLE cycle after the frame ends.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   load_valid - a parallel word is offered on load_data
//   load_data  - word to send; captured only when the load is accepted
//   load_ready - high only in IDLE
//   ser_out    - serial bit; 0 whenever ser_valid is 0
//   ser_valid  - ser_out carries a frame bit this cycle
//   done       - one-cycle pulse after the last frame bit
//
// Optional feature (macro PISO_PARITY_EN): an even-parity bit is appended
// after the data bits, so each frame carries WIDTH+1 bits.
module piso_shift_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             done_nxt;
    logic             accept;
    logic             last_bit;
`ifdef PISO_PARITY_EN
    logic             parity_bit;
`endif

    assign accept   = load_valid && (state == ST_IDLE);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
            done  <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg <= load_data;
                        cnt   <= '0;
`ifdef PISO_PARITY_EN
                        parity_bit <= ^load_data;
`endif
                    end
                end
                ST_SHIFT: begin
                    shreg <= {1'b0, shreg[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state logic. done is registered, so it is raised on the edge
    // that moves the FSM back into IDLE.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) begin
`ifdef PISO_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
            ST_PARITY: begin
                // Reachable only when the parity feature is built in.
                // In the default build this branch only recovers to IDLE.
                state_nxt = ST_IDLE;
`ifdef PISO_PARITY_EN
                done_nxt  = 1'b1;
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from registers only, so no input reaches an
    // output through combinational logic.
    always_comb begin
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        case (state)
            ST_IDLE:  load_ready = 1'b1;
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_out   = shreg[0];
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                ser_valid = 1'b1;
                ser_out   = parity_bit;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: self-checking bench for piso_shift_tx (WIDTH=4).
// The reference model is a queue of the serial bits still owed to the link:
//   - an accepted word pushes its bits LSB first (plus parity when enabled);
//   - each clock pops one bit;
//   - done is expected in the cycle after the queue empties.
// Define PISO_PARITY_EN for both the bench and the RTL to test the parity build.
module tb_piso_shift_tx;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         done;

    piso_shift_tx #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic         exp_q[$];
    logic         done_m    = 1'b0;
    logic [W-1:0] last_word = '0;
    logic [W-1:0] rx        = '0;   // behaves like the right-shift receiver

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge: check outputs against the model, drive the inputs
    // for the next rising edge, advance the model, then wait for the next negedge.
    task automatic cyc(input logic v, input logic [W-1:0] d);
        logic idle;
        idle = (exp_q.size() == 0);
        chk("load_ready", 32'(load_ready), 32'(idle));
        chk("ser_valid",  32'(ser_valid),  32'(!idle));
        chk("ser_out",    32'(ser_out),    idle ? 32'd0 : 32'(exp_q[0]));
        chk("done",       32'(done),       32'(done_m));
`ifndef PISO_PARITY_EN
        if (done_m) chk("rx_word", 32'(rx), 32'(last_word));
        if (ser_valid) rx = {ser_out, rx[W-1:1]};
`endif
        load_valid = v;
        load_data  = d;
        if (idle && v) begin
            for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
`ifdef PISO_PARITY_EN
            exp_q.push_back(^d);
`endif
            last_word = d;
            done_m    = 1'b0;
        end else if (!idle) begin
            void'(exp_q.pop_front());
            done_m = (exp_q.size() == 0);
        end else begin
            done_m = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between clock edges. The outputs must drop
    // before the next clock edge arrives.
    task automatic async_reset();
        load_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_load_ready", 32'(load_ready), 32'd1);
        chk("rst_ser_valid",  32'(ser_valid),  32'd0);
        chk("rst_ser_out",    32'(ser_out),    32'd0);
        chk("rst_done",       32'(done),       32'd0);
        exp_q.delete();
        done_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; load_valid = 1'b0; load_data = '0;
        // Test 1: reset. Hold it across a few edges, then release at a negedge.
        async_reset();
        repeat (3) cyc(1'b0, '0);

        // Test 2: single frame 1011
        cyc(1'b1, 4'b1011);
        repeat (6) cyc(1'b0, 4'b0000);

        // Test 3: load offered while busy is ignored; 0110 is taken in the next IDLE cycle
        cyc(1'b1, 4'b1011);
        cyc(1'b0, 4'b0000);
        repeat (10) cyc(1'b1, 4'b0110);
        repeat (2) cyc(1'b0, 4'b0000);

        // Test 4: mid-frame reset after the 2nd bit
        cyc(1'b1, 4'b1111);
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0000);
        async_reset();
        repeat (6) cyc(1'b0, 4'b0000);

        // Test 5: back-to-back frames 0001 then 1000
        cyc(1'b1, 4'b0001);
        repeat (W) cyc(1'b1, 4'b1000);   // ignored while busy
        repeat (W + 3) cyc(1'b1, 4'b1000);
        repeat (8) cyc(1'b0, 4'b0000);

        // Test 6 (parity build): 0011 gives parity bit 0
        cyc(1'b1, 4'b0011);
        repeat (8) cyc(1'b0, 4'b0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 3) != 0), W'($urandom));
        repeat (8) cyc(1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
